tone_mixer: RTL and testbench

Upstream source of the 32-bit mix_down sample word consumed by the audio output stage.
- Generates NUM_VOICES square-wave tones; each voice's frequency is set by a half-period count in CLOCK_50 cycles.
- On each codec sample request, snapshots all voice polarities, sums them sequentially with saturation, and presents one registered sample with a valid strobe.

---
 rtl/tone_mixer.sv | 151 +++++++++++++++
 tb/tb_tone_mixer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_mixer.sv
// tone_mixer: NUM_VOICES square-wave oscillators, summed with saturation into one
// registered 32-bit sample per codec request. Define TONE_MIXER_ATTEN_EN to scale by 1/NUM_VOICES.
module tone_mixer #(
    parameter int unsigned        NUM_VOICES = 4,
    parameter int unsigned        HP_WIDTH   = 20,
    parameter logic signed [31:0] AMPLITUDE  = 32'sd8388608
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [NUM_VOICES*HP_WIDTH-1:0] half_period,
    input  logic                           sample_req,
    output logic [31:0]                    mix_down,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [HP_WIDTH-1:0] HP_ONE   = 1;
    localparam logic [IDX_W-1:0]    IDX_ONE  = 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);

    localparam logic signed [33:0] AMP_POS = {{2{AMPLITUDE[31]}}, AMPLITUDE};
    localparam logic signed [33:0] AMP_NEG = -AMP_POS;
    localparam logic signed [32:0] ACC_MAX = {1'b0, {32{1'b1}}};
    localparam logic signed [32:0] ACC_MIN = {1'b1, 32'h0000_0000};
    localparam logic signed [31:0] OUT_MAX = 32'h7FFF_FFFF;
    localparam logic signed [31:0] OUT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    logic [NUM_VOICES-1:0] eff_en;
    logic [NUM_VOICES-1:0] pol;

    // A voice with a zero half-period is treated exactly like a disabled voice.
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        logic [HP_WIDTH-1:0] hp;
        logic [HP_WIDTH-1:0] count;
        logic                phase;

        assign hp        = half_period[g*HP_WIDTH +: HP_WIDTH];
        assign eff_en[g] = voice_en[g] && (hp != '0);
        assign pol[g]    = phase;

        always_ff @(posedge CLOCK_50) begin
            if (reset || !eff_en[g]) begin
                count <= '0;
                phase <= 1'b0;
            end else if (count == hp - HP_ONE) begin
                count <= '0;
                phase <= ~phase;
            end else begin
                count <= count + HP_ONE;
            end
        end
    end

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [NUM_VOICES-1:0] snap_pol;
    logic [NUM_VOICES-1:0] snap_en;
    logic signed [32:0]    acc;
    logic signed [33:0]    addend;
    logic signed [33:0]    sum;
    logic signed [32:0]    acc_next;
    logic signed [31:0]    sat32;
    logic signed [31:0]    result;

    // Partial sums clamp at the 33-bit bounds so long voice lists never wrap.
    always_comb begin
        addend = '0;
        if (snap_en[idx]) begin
            addend = snap_pol[idx] ? AMP_POS : AMP_NEG;
        end
        sum = {acc[32], acc} + addend;
        if (sum[33] != sum[32]) begin
            acc_next = sum[33] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = sum[32:0];
        end
    end

    always_comb begin
        if (acc[32] != acc[31]) begin
            sat32 = acc[32] ? OUT_MIN : OUT_MAX;
        end else begin
            sat32 = acc[31:0];
        end
    end

`ifdef TONE_MIXER_ATTEN_EN
    localparam int unsigned ATTEN_SHIFT = $clog2(NUM_VOICES);
    assign result = sat32 >>> ATTEN_SHIFT;
`else
    assign result = sat32;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            snap_pol  <= '0;
            snap_en   <= '0;
            acc       <= '0;
            mix_down  <= '0;
            mix_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (sample_req && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_req) begin
                        snap_pol <= pol;
                        snap_en  <= eff_en;
                        acc      <= '0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    idx <= idx + IDX_ONE;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    mix_down  <= result;
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_mixer.sv
// Self-checking bench for tone_mixer: directed vector table, hand-written corner
// sequences and randomized traffic compared every cycle against a behavioural model.
module tb_tone_mixer;

    localparam int NV  = 4;
    localparam int HPW = 20;
    localparam longint AMP   = 64'sd8388608;
    localparam longint AMP_S = 64'sd1073741824;

    logic            CLOCK_50 = 1'b0;
    logic            reset = 1'b1;
    logic [NV-1:0]   voice_en = '0;
    logic [HPW-1:0]  hp_arr [NV];
    logic [NV*HPW-1:0] half_period;
    logic            sample_req = 1'b0;

    logic [31:0] md, md_s;
    logic        mv, mv_s, bz, bz_s, ov, ov_s;

    assign half_period = {hp_arr[3], hp_arr[2], hp_arr[1], hp_arr[0]};

    always #10 CLOCK_50 = ~CLOCK_50;

    tone_mixer #(.NUM_VOICES(NV), .HP_WIDTH(HPW)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .voice_en(voice_en),
        .half_period(half_period), .sample_req(sample_req),
        .mix_down(md), .mix_valid(mv), .busy(bz), .overrun(ov)
    );

    tone_mixer #(.NUM_VOICES(NV), .HP_WIDTH(HPW), .AMPLITUDE(32'sh40000000)) dut_sat (
        .CLOCK_50(CLOCK_50), .reset(reset), .voice_en(voice_en),
        .half_period(half_period), .sample_req(sample_req),
        .mix_down(md_s), .mix_valid(mv_s), .busy(bz_s), .overrun(ov_s)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned vcount   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: a voice running for k cycles with half-period h is high
    // when floor(k/h) is odd; a request takes NV+1 cycles and blocks others.
    longint       k [NV];
    int           m_cnt = 0;
    logic         m_valid = 1'b0, m_over = 1'b0;
    logic [31:0]  m_mix = '0, m_mix_s = '0, m_pend = '0, m_pend_s = '0;

    function automatic logic [31:0] ref_mix(input longint amp);
        longint acc = 0;
        for (int i = 0; i < NV; i++) begin
            longint h = longint'(hp_arr[i]);
            if (voice_en[i] && h != 0) begin
                acc += (((k[i] / h) % 2) == 1) ? amp : -amp;
                if (acc > 64'sd4294967295) acc = 64'sd4294967295;
                if (acc < -64'sd4294967296) acc = -64'sd4294967296;
            end
        end
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        return 32'(acc);
    endfunction

    initial begin
        for (int i = 0; i < NV; i++) begin
            k[i] = 0;
            hp_arr[i] = '0;
        end
        forever begin
            @(posedge CLOCK_50);
            if (reset) begin
                m_cnt = 0; m_valid = 1'b0; m_over = 1'b0; m_mix = '0; m_mix_s = '0;
                for (int i = 0; i < NV; i++) k[i] = 0;
            end else begin
                m_valid = 1'b0;
                if (m_cnt > 0) begin
                    if (sample_req) m_over = 1'b1;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_valid = 1'b1;
                        m_mix   = m_pend;
                        m_mix_s = m_pend_s;
                    end
                end else if (sample_req) begin
                    m_pend   = ref_mix(AMP);
                    m_pend_s = ref_mix(AMP_S);
                    m_cnt    = NV + 1;
                end
                for (int i = 0; i < NV; i++) begin
                    if (voice_en[i] && hp_arr[i] != '0) k[i]++;
                    else k[i] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK_50);
            check("model_main", {29'd0, md, mv, bz, ov},
                  {29'd0, m_mix, m_valid, (m_cnt != 0), m_over});
            check("model_sat", {29'd0, md_s, mv_s, bz_s, ov_s},
                  {29'd0, m_mix_s, m_valid, (m_cnt != 0), m_over});
        end
    end

    initial begin
        forever begin
            @(posedge CLOCK_50);
            if (mv) vcount++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [NV-1:0]  en;
        logic [HPW-1:0] hp;
        int unsigned    settle;
        logic [31:0]    exp_mix;
        logic [31:0]    exp_sat;
    } vec_t;

    vec_t tbl [13];

    task automatic wait_valid(output int unsigned lat);
        lat = 0;
        while (!mv && lat < 12) begin
            @(negedge CLOCK_50);
            lat++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_req = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int unsigned lat;
        voice_en = '0;
        @(negedge CLOCK_50);
        voice_en = v.en;
        for (int i = 0; i < NV; i++) hp_arr[i] = v.hp;
        repeat (v.settle) @(negedge CLOCK_50);
        sample_req = 1'b1;
        @(negedge CLOCK_50);
        sample_req = 1'b0;
        wait_valid(lat);
        check($sformatf("tbl%0d_latency", idx), 64'(lat), 64'd5);
        check($sformatf("tbl%0d_mix", idx), 64'(md), 64'(v.exp_mix));
        check($sformatf("tbl%0d_sat", idx), 64'(md_s), 64'(v.exp_sat));
        @(negedge CLOCK_50);
    endtask

    initial begin
        int unsigned v0;
        tbl[0]  = '{4'b0001, 20'd5,    0,    32'hFF80_0000, 32'hC000_0000};
        tbl[1]  = '{4'b0001, 20'd5,    4,    32'hFF80_0000, 32'hC000_0000};
        tbl[2]  = '{4'b0001, 20'd5,    5,    32'h0080_0000, 32'h4000_0000};
        tbl[3]  = '{4'b0001, 20'd5,    9,    32'h0080_0000, 32'h4000_0000};
        tbl[4]  = '{4'b0001, 20'd5,    10,   32'hFF80_0000, 32'hC000_0000};
        tbl[5]  = '{4'b1111, 20'd1000, 0,    32'hFE00_0000, 32'h8000_0000};
        tbl[6]  = '{4'b1111, 20'd1000, 1000, 32'h0200_0000, 32'h7FFF_FFFF};
        tbl[7]  = '{4'b0011, 20'd3,    3,    32'h0100_0000, 32'h7FFF_FFFF};
        tbl[8]  = '{4'b1111, 20'd0,    7,    32'h0000_0000, 32'h0000_0000};
        tbl[9]  = '{4'b0110, 20'd4,    6,    32'h0100_0000, 32'h7FFF_FFFF};
        tbl[10] = '{4'b1010, 20'd1,    0,    32'hFF00_0000, 32'h8000_0000};
        tbl[11] = '{4'b1010, 20'd1,    1,    32'h0100_0000, 32'h7FFF_FFFF};
        tbl[12] = '{4'b0111, 20'd2,    2,    32'h0180_0000, 32'h7FFF_FFFF};

        // Reset, then idle
        do_reset();
        v0 = vcount;
        repeat (100) @(negedge CLOCK_50);
        check("idle_valid_count", 64'(vcount - v0), 64'd0);
        check("idle_mix", 64'(md), 64'd0);
        check("idle_overrun", 64'(ov), 64'd0);
        check("idle_busy", 64'(bz), 64'd0);

        for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

        // Overrun: requests two cycles apart, only the first is served
        do_reset();
        v0 = vcount;
        sample_req = 1'b1;
        @(negedge CLOCK_50);
        sample_req = 1'b0;
        @(negedge CLOCK_50);
        sample_req = 1'b1;
        @(negedge CLOCK_50);
        sample_req = 1'b0;
        check("ovr_set", 64'(ov), 64'd1);
        check("ovr_busy", 64'(bz), 64'd1);
        repeat (10) @(negedge CLOCK_50);
        check("ovr_valid_count", 64'(vcount - v0), 64'd1);
        repeat (20) @(negedge CLOCK_50);
        check("ovr_sticky", 64'(ov), 64'd1);
        do_reset();
        check("ovr_cleared", 64'(ov), 64'd0);

        // Request landing on the DONE cycle is refused
        v0 = vcount;
        sample_req = 1'b1;
        @(negedge CLOCK_50);
        sample_req = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        sample_req = 1'b1;
        @(negedge CLOCK_50);
        sample_req = 1'b0;
        check("done_req_valid", 64'(mv), 64'd1);
        check("done_req_overrun", 64'(ov), 64'd1);
        check("done_req_busy", 64'(bz), 64'd0);
        repeat (10) @(negedge CLOCK_50);
        check("done_req_valid_count", 64'(vcount - v0), 64'd1);

        // Reset in the middle of accumulation
        do_reset();
        run_vec(tbl[0], 100);
        v0 = vcount;
        sample_req = 1'b1;
        @(negedge CLOCK_50);
        sample_req = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        check("rst_mid_valid", 64'(mv), 64'd0);
        check("rst_mid_busy", 64'(bz), 64'd0);
        check("rst_mid_mix", 64'(md), 64'd0);
        repeat (10) @(negedge CLOCK_50);
        check("rst_mid_no_valid", 64'(vcount - v0), 64'd0);
        sample_req = 1'b1;
        @(negedge CLOCK_50);
        sample_req = 1'b0;
        begin
            int unsigned lat;
            wait_valid(lat);
            check("rst_after_latency", 64'(lat), 64'd5);
            check("rst_after_mix", 64'(md), 64'hFF80_0000);
        end

        // Randomized traffic, checked by the per-cycle model
        for (int seg = 0; seg < 30; seg++) begin
            reset = 1'b1;
            voice_en = '0;
            sample_req = 1'b0;
            @(negedge CLOCK_50);
            reset = 1'b0;
            for (int i = 0; i < NV; i++) hp_arr[i] = 20'($urandom_range(0, 9));
            voice_en = 4'($urandom);
            for (int c = 0; c < 80; c++) begin
                sample_req = ($urandom_range(0, 4) == 0);
                reset = ($urandom_range(0, 59) == 0);
                @(negedge CLOCK_50);
            end
            sample_req = 1'b0;
            reset = 1'b0;
        end

        repeat (10) @(negedge CLOCK_50);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
